// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Streaming instruction encoder and IMEM loader. Symbolic instruction
// descriptors arrive over a valid/ready handshake, are assembled into 32-bit
// MIPS words and written to consecutive IMEM addresses starting at 0. Each
// program is closed with a self-loop halt word (j <own address>).
//
// Handshake: a descriptor transfers on the rising edge where
// in_valid && in_ready. in_ready depends only on state, pointer, start and
// finish (never on in_valid); the descriptor need only be stable in the
// transfer cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse, (re)opens a program at address 0
//   finish              level, writes the halt word and closes the program
//   in_valid/in_ready   descriptor handshake
//   in_kind             instruction kind (0..20 legal, 21..31 illegal)
//   in_rs/rt/rd/shamt   register and shift fields
//   in_imm              I-type immediate / branch offset
//   in_target           J-type word target
//   imem_we/addr/wdata  registered IMEM write port (one-cycle strobe)
//   word_count          words written in the current program, halt included
//   done                halt word written, program closed
//   err_illegal         sticky, an illegal kind was accepted
//   fsm_state           current FSM state (0 idle, 1 load, 2 done)
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err_illegal,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    // ------------------------------------------------------------------
    // Encoder: kind -> format, opcode/funct, field masking
    // ------------------------------------------------------------------
    logic       is_r;
    logic       is_j;
    logic       is_shift;
    logic       is_jr;
    logic       legal;
    logic [5:0] code;      // funct for R-type, opcode otherwise
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic [4:0] sa_f;
    logic [31:0] enc_word;

    always_comb begin
        is_r     = 1'b0;
        is_j     = 1'b0;
        is_shift = 1'b0;
        is_jr    = 1'b0;
        legal    = 1'b1;
        code     = 6'h00;
        case (in_kind)
            5'd0:  begin is_r = 1'b1; code = 6'h20; end
            5'd1:  begin is_r = 1'b1; code = 6'h22; end
            5'd2:  begin is_r = 1'b1; code = 6'h24; end
            5'd3:  begin is_r = 1'b1; code = 6'h25; end
            5'd4:  begin is_r = 1'b1; code = 6'h2a; end
            5'd5:  begin is_r = 1'b1; code = 6'h26; end
            5'd6:  begin is_r = 1'b1; code = 6'h27; end
            5'd7:  begin is_r = 1'b1; is_shift = 1'b1; code = 6'h00; end
            5'd8:  begin is_r = 1'b1; is_shift = 1'b1; code = 6'h02; end
            5'd9:  begin is_r = 1'b1; code = 6'h2b; end
            5'd10: begin is_r = 1'b1; is_jr = 1'b1; code = 6'h08; end
            5'd11: code = 6'h08;
            5'd12: code = 6'h0c;
            5'd13: code = 6'h0d;
            5'd14: code = 6'h0e;
            5'd15: code = 6'h23;
            5'd16: code = 6'h2b;
            5'd17: code = 6'h04;
            5'd18: code = 6'h05;
            5'd19: begin is_j = 1'b1; code = 6'h02; end
            5'd20: begin is_j = 1'b1; code = 6'h03; end
            default: legal = 1'b0;
        endcase

        // Shifts take their source from rt, so rs is zeroed; only shifts
        // carry a shift amount; jr uses rs alone.
        rs_f = is_shift ? 5'd0 : in_rs;
        rt_f = is_jr ? 5'd0 : in_rt;
        rd_f = is_jr ? 5'd0 : in_rd;
        sa_f = is_shift ? in_shamt : 5'd0;

        if (is_r) begin
            enc_word = {6'h00, rs_f, rt_f, rd_f, sa_f, code};
        end else if (is_j) begin
            enc_word = {code, in_target};
        end else begin
            enc_word = {code, in_rs, in_rt, in_imm};
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Word D-1 is kept free for the halt word, so the pointer stops there.
    assign in_ready  = (state == S_LOAD) && !start && !finish && (ptr != PTR_MAX);
    assign fsm_state = state;

    logic accept;
    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            word_count  <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // finish is ignored outside LOAD
                    if (start) begin
                        state       <= S_LOAD;
                        ptr         <= '0;
                        word_count  <= '0;
                        done        <= 1'b0;
                        err_illegal <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        ptr         <= '0;
                        word_count  <= '0;
                        err_illegal <= 1'b0;
                    end else if (finish) begin
                        // Halt: jump to its own word address.
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= {6'h02, 26'(ptr)};
                        word_count <= word_count + CNT_ONE;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (accept) begin
                        if (legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ptr;
                            imem_wdata <= enc_word;
                            word_count <= word_count + CNT_ONE;
                            ptr        <= ptr + PTR_ONE;
                        end else begin
                            // Consumed but not written; pointer holds.
                            err_illegal <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Bench for instr_encoder. Two instances: a default one (ADDR_W=8) for the
// encode / halt / illegal / reset / restart scenarios, and a small one
// (ADDR_W=2) for the full-memory scenario. Descriptor fields are shared;
// each instance has its own start/finish/valid. Expected IMEM writes are
// pushed into per-instance queues and popped by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        start, finish, in_valid;
    logic        s_start, s_finish, s_valid;
    logic [4:0]  in_kind, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, imem_we, done, err_illegal;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  word_count;
    logic [1:0]  fsm_state;

    logic        s_in_ready, s_imem_we, s_done, s_err_illegal;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [2:0]  s_word_count;
    logic [1:0]  s_fsm_state;

    logic [39:0] exp_q[$];
    logic [33:0] exp_s_q[$];

    int vectors     = 0;
    int miscompares = 0;

    instr_encoder #(.ADDR_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .done(done), .err_illegal(err_illegal),
        .fsm_state(fsm_state)
    );

    instr_encoder #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .finish(s_finish),
        .in_valid(s_valid), .in_ready(s_in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .word_count(s_word_count), .done(s_done), .err_illegal(s_err_illegal),
        .fsm_state(s_fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected write: addr %0h data %0h expected none", imem_addr, imem_wdata);
            end else begin
                check("imem write", {24'd0, imem_addr, imem_wdata}, {24'd0, exp_q.pop_front()});
            end
        end
        if (s_imem_we) begin
            if (exp_s_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected small write: addr %0h data %0h expected none", s_imem_addr, s_imem_wdata);
            end else begin
                check("small imem write", {30'd0, s_imem_addr, s_imem_wdata}, {30'd0, exp_s_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sa,
                              input logic [15:0] imm, input logic [25:0] tgt);
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sa;
        in_imm = imm; in_target = tgt;
    endtask

    // Present one descriptor; it must be accepted in this cycle.
    task automatic send(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa,
                        input logic [15:0] imm, input logic [25:0] tgt,
                        input logic push, input logic [7:0] ea, input logic [31:0] ed);
        set_fields(k, rs, rt, rd, sa, imm, tgt);
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready before accept", in_ready, 1);
        if (push) exp_q.push_back({ea, ed});
        next_cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    // Close the program; the halt word lands at ea, word_count becomes wc.
    task automatic close_prog(input logic [7:0] ea, input logic [8:0] wc);
        finish = 1'b1;
        @(negedge clk);
        check("in_ready during finish", in_ready, 0);
        exp_q.push_back({ea, {6'h02, 18'd0, ea}});
        next_cycle();
        finish   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("done after halt", done, 1);
        check("word_count after halt", word_count, wc);
        check("state after halt", fsm_state, 2);
        next_cycle();
    endtask

    logic [31:0] s_data [3];

    // ---------------- stimulus ----------------
    initial begin
        s_data = '{32'h00220020, 32'h00220820, 32'h00221020};
        rst = 1'b1;
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        s_start = 1'b0; s_finish = 1'b0; s_valid = 1'b0;
        set_fields(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        @(negedge clk);
        check("reset outputs", {in_ready, imem_we, imem_addr, imem_wdata, word_count, done, err_illegal, fsm_state}, 64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Program 1: encodes of every format, back to back.
        pulse_start();
        send(5'd0,  5'd1,  5'd2, 5'd3, 5'd0,  16'h0000, 26'd0, 1, 8'd0, 32'h00221820); // add
        send(5'd11, 5'd0,  5'd8, 5'd0, 5'd0,  16'hFFFF, 26'd0, 1, 8'd1, 32'h2008FFFF); // addi
        in_valid = 1'b0;
        @(negedge clk);
        check("word_count after two", word_count, 2);
        next_cycle();
        send(5'd7,  5'd7,  5'd5, 5'd4, 5'd3,  16'h0000, 26'd0, 1, 8'd2, 32'h000520C0); // sll, rs masked
        send(5'd15, 5'd29, 5'd9, 5'd0, 5'd0,  16'h0004, 26'd0, 1, 8'd3, 32'h8FA90004); // lw
        send(5'd20, 5'd0,  5'd0, 5'd0, 5'd0,  16'h0000, 26'h40, 1, 8'd4, 32'h0C000040); // jal
        send(5'd10, 5'd31, 5'd9, 5'd9, 5'd9,  16'h0000, 26'd0, 1, 8'd5, 32'h03E00008); // jr, rt/rd/shamt masked
        send(5'd17, 5'd1,  5'd2, 5'd0, 5'd0,  16'hFFFE, 26'd0, 1, 8'd6, 32'h1022FFFE); // beq
        send(5'd8,  5'd3,  5'd6, 5'd7, 5'd31, 16'h0000, 26'd0, 1, 8'd7, 32'h00063FC2); // srl
        send(5'd19, 5'd0,  5'd0, 5'd0, 5'd0,  16'h0000, 26'h3FFFFFF, 1, 8'd8, 32'h0BFFFFFF); // j
        send(5'd0,  5'd1,  5'd2, 5'd3, 5'd5,  16'h0000, 26'd0, 1, 8'd9, 32'h00221820); // add, shamt masked
        in_valid = 1'b0;
        close_prog(8'd10, 9'd11);

        // finish in DONE is ignored.
        finish = 1'b1;
        next_cycle();
        finish = 1'b0;
        @(negedge clk);
        check("word_count in done", word_count, 11);
        check("done held", done, 1);
        next_cycle();

        // Halt with a held descriptor: finish wins, descriptor not written.
        pulse_start();
        @(negedge clk);
        check("done cleared by start", done, 0);
        check("word_count cleared", word_count, 0);
        next_cycle();
        send(5'd0,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1, 8'd0, 32'h00221820);
        send(5'd11, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1, 8'd1, 32'h2008FFFF);
        set_fields(5'd3, 5'd9, 5'd9, 5'd9, 5'd0, 16'h0000, 26'd0);
        close_prog(8'd2, 9'd3);

        // Illegal kind between two adds, then reset the cycle after an accept.
        pulse_start();
        send(5'd0,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1, 8'd0, 32'h00221820);
        send(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 0, 8'd0, 32'h0);
        send(5'd0,  5'd4, 5'd5, 5'd6, 5'd0, 16'h0000, 26'd0, 1, 8'd1, 32'h00853020);
        in_valid = 1'b0;
        @(negedge clk);
        check("err_illegal set", err_illegal, 1);
        check("word_count skips illegal", word_count, 2);
        next_cycle();
        send(5'd0,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 0, 8'd2, 32'h0);
        rst = 1'b1;
        #1;
        check("outputs after mid reset", {imem_we, imem_addr, imem_wdata, word_count, done, err_illegal, fsm_state}, 64'd0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_ready idle after reset", in_ready, 0);
            next_cycle();
        end
        in_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check("state load after start", fsm_state, 1);
        next_cycle();

        // Restart inside LOAD returns to address 0.
        send(5'd0,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1, 8'd0, 32'h00221820);
        send(5'd11, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1, 8'd1, 32'h2008FFFF);
        start = 1'b1;
        @(negedge clk);
        check("in_ready during start", in_ready, 0);
        next_cycle();
        start = 1'b0;
        send(5'd0,  5'd4, 5'd5, 5'd6, 5'd0, 16'h0000, 26'd0, 1, 8'd0, 32'h00853020);
        in_valid = 1'b0;
        @(negedge clk);
        check("word_count after restart", word_count, 1);
        next_cycle();
        close_prog(8'd1, 9'd2);

        // Empty program: halt at address 0.
        pulse_start();
        close_prog(8'd0, 9'd1);

        // Small instance: fill to D-1 then halt into the last word.
        s_start = 1'b1;
        next_cycle();
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_fields(5'd0, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0000, 26'd0);
            s_valid = 1'b1;
            @(negedge clk);
            check("small in_ready", s_in_ready, (i < 3));
            if (i < 3) exp_s_q.push_back({2'(i), s_data[i]});
            next_cycle();
        end
        s_finish = 1'b1;
        @(negedge clk);
        check("small word_count full", s_word_count, 3);
        check("small in_ready on finish", s_in_ready, 0);
        exp_s_q.push_back({2'd3, 32'h08000003});
        next_cycle();
        s_finish = 1'b0;
        s_valid  = 1'b0;
        @(negedge clk);
        check("small done", s_done, 1);
        check("small word_count", s_word_count, 4);
        next_cycle();

        repeat (3) next_cycle();
        check("pending writes", exp_q.size(), 0);
        check("pending small writes", exp_s_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
